regfile_wb_unit: RTL

Writeback stage directly upstream of register_file; drives its single write port (we/wa/wd). Merges single-cycle ALU results with long-latency load/LSU responses, buffering LSU data in a small FIFO. Maintains a pending-register scoreboard so decode can stall on RAW hazards against outstanding loads. x0 writes are filtered here, not left to the register file.

---
 rtl/rv_wb_pkg.sv | 14 +
 rtl/regfile_wb_unit_if.sv | 44 ++++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/regfile_wb_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared widths and the writeback entry payload carried from the LSU
// through the response FIFO to the register-file write port.
package rv_wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_unit_if.sv
// Bundle of the writeback unit's ALU/LSU/issue inputs, hazard queries and
// register-file write port; slave is the writeback unit, master its environment.
interface regfile_wb_unit_if
    import rv_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic [XLEN-1:0]       rf_wd;
    logic [CNT_W-1:0]      fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, chk_rs1, chk_rs2,
        input  lsu_ready, rs1_busy, rs2_busy,
        input  rf_we, rf_wa, rf_wd, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2,
        output lsu_ready, rs1_busy, rs2_busy,
        output rf_we, rf_wa, rf_wd, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering LSU writeback entries until the write port is free.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output wb_entry_t        pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_unit.sv
// Writeback stage: arbitrates ALU results against buffered LSU responses onto
// the register-file write port and tracks registers with outstanding loads.
module regfile_wb_unit
    import rv_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_unit_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  lsu_ready;
    logic                  push;
    logic                  pop;
    logic                  alu_req;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]       rf_wd_q, rf_wd_d;
    logic                  rf_from_fifo_q, rf_from_fifo_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    assign lsu_ready     = !reset && !fifo_full;
    assign push          = bus.lsu_valid && lsu_ready;
    assign push_entry.rd   = bus.lsu_rd;
    assign push_entry.data = bus.lsu_data;
    assign alu_req       = bus.alu_valid && (bus.alu_rd != '0);
    assign pop           = !alu_req && !fifo_empty;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ALU has priority; an LSU entry to x0 still drains but never writes.
    always_comb begin
        rf_we_d        = 1'b0;
        rf_wa_d        = rf_wa_q;
        rf_wd_d        = rf_wd_q;
        rf_from_fifo_d = 1'b0;
        if (alu_req) begin
            rf_we_d = 1'b1;
            rf_wa_d = bus.alu_rd;
            rf_wd_d = bus.alu_data;
        end else if (pop) begin
            rf_we_d        = (head.rd != '0);
            rf_wa_d        = head.rd;
            rf_wd_d        = head.data;
            rf_from_fifo_d = 1'b1;
        end
    end

    // Clear on a committed LSU write; a same-edge issue to that rd re-arms it.
    always_comb begin
        pending_d = pending_q;
        if (rf_we_q && rf_from_fifo_q) begin
            pending_d[rf_wa_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q        <= 1'b0;
            rf_wa_q        <= '0;
            rf_wd_q        <= '0;
            rf_from_fifo_q <= 1'b0;
            pending_q      <= '0;
        end else begin
            rf_we_q        <= rf_we_d;
            rf_wa_q        <= rf_wa_d;
            rf_wd_q        <= rf_wd_d;
            rf_from_fifo_q <= rf_from_fifo_d;
            pending_q      <= pending_d;
        end
    end

    assign bus.lsu_ready  = lsu_ready;
    assign bus.rs1_busy   = (bus.chk_rs1 != '0) && pending_q[bus.chk_rs1];
    assign bus.rs2_busy   = (bus.chk_rs2 != '0) && pending_q[bus.chk_rs2];
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wa      = rf_wa_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.fifo_count = fifo_count;

endmodule
